// File: rtl/mem_tile_pkg.sv
// Shared memory-tile definitions: scheduler FSM states and default SRAM geometry.
package mem_tile_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } sched_state_e;

    localparam int unsigned MEM_NUM_WORDS  = 4096;
    localparam int unsigned MEM_DATA_WIDTH = 512;

endpackage

// File: rtl/rr_arb_onehot.sv
// Round-robin priority pick: first set request at or above ptr, wrapping modulo N.
module rr_arb_onehot #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx,
    output logic            valid
);

    always_comb begin
        int unsigned c;
        c     = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            c = 32'(ptr) + i;
            if (c >= N) c = c - N;
            if (!valid && req[c]) begin
                valid  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IdxW'(c);
            end
        end
    end

endmodule

// File: rtl/mem_sram_sched.sv
// Shares one latency-1 SRAM between NumPorts OBI requesters, with a zero-init sequencer.
module mem_sram_sched
    import mem_tile_pkg::*;
#(
    parameter int unsigned NumPorts   = 2,
    parameter int unsigned NumWords   = MEM_NUM_WORDS,
    parameter int unsigned DataWidth  = MEM_DATA_WIDTH,
    parameter bit          InitEnable = 1'b1,
    parameter int unsigned AddrWidth  = $clog2(NumWords)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  init_start_i,
    output logic                                  init_done_o,
    input  logic [NumPorts-1:0]                   req_i,
    output logic [NumPorts-1:0]                   gnt_o,
    input  logic [NumPorts-1:0]                   we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]    addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]    wdata_i,
    input  logic [NumPorts-1:0][DataWidth/8-1:0]  be_i,
    output logic [NumPorts-1:0]                   rvalid_o,
    output logic [DataWidth-1:0]                  rdata_o,
    output logic                                  mem_req_o,
    output logic                                  mem_we_o,
    output logic [AddrWidth-1:0]                  mem_addr_o,
    output logic [DataWidth-1:0]                  mem_wdata_o,
    output logic [DataWidth/8-1:0]                mem_be_o,
    input  logic [DataWidth-1:0]                  mem_rdata_i
);

    localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    sched_state_e            state_q, state_d;
    logic [AddrWidth-1:0]    init_cnt_q, init_cnt_d;
    logic [PtrW-1:0]         rr_ptr_q;
    logic [NumPorts-1:0]     rsp_sel_q;

    logic [NumPorts-1:0]     arb_req, arb_gnt;
    logic [PtrW-1:0]         arb_idx;
    logic                    arb_valid;

    // Requests are only visible to the arbiter in RUN, so grants are zero elsewhere.
    assign arb_req = (state_q == RUN) ? req_i : '0;

    rr_arb_onehot #(.N(NumPorts), .IdxW(PtrW)) u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        case (state_q)
            BOOT: state_d = InitEnable ? INIT : RUN;
            INIT: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = init_cnt_q;
                mem_be_o   = '1;
                if (init_cnt_q == AddrWidth'(NumWords - 1)) begin
                    state_d    = RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (arb_valid) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = we_i[arb_idx];
                    mem_addr_o  = addr_i[arb_idx];
                    mem_wdata_o = wdata_i[arb_idx];
                    mem_be_o    = be_i[arb_idx];
                end
                if (init_start_i) state_d = INIT;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= BOOT;
            init_cnt_q <= '0;
            rr_ptr_q   <= '0;
            rsp_sel_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            // Response tracking is never flushed: the last RUN grant answers in the first INIT cycle.
            rsp_sel_q  <= arb_gnt;
            if (arb_valid)
                rr_ptr_q <= (arb_idx == PtrW'(NumPorts - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    assign gnt_o       = arb_gnt;
    assign rvalid_o    = rsp_sel_q;
    assign rdata_o     = mem_rdata_i;
    assign init_done_o = (state_q == RUN);

endmodule

// File: tb/tb_mem_sram_sched.sv
// Randomized self-checking bench for mem_sram_sched against a cycle-level behavioural model.
module tb_mem_sram_sched;

    localparam int NP = 2, NW = 16, DW = 32, AW = 4, BW = 4;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic                   init_start, init_done;
    logic [NP-1:0]          req, gnt, we, rvalid;
    logic [NP-1:0][AW-1:0]  addr;
    logic [NP-1:0][DW-1:0]  wdata;
    logic [NP-1:0][BW-1:0]  be;
    logic [DW-1:0]          rdata, mem_wdata, mem_rdata;
    logic                   mem_req, mem_we;
    logic [AW-1:0]          mem_addr;
    logic [BW-1:0]          mem_be;

    mem_sram_sched #(.NumPorts(NP), .NumWords(NW), .DataWidth(DW), .InitEnable(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .init_start_i(init_start), .init_done_o(init_done),
        .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
        .rvalid_o(rvalid), .rdata_o(rdata), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
    );

    // Three-port instance without init, for the wrap-around pick.
    logic                 c_rst_n = 1'b0, c_start = 1'b0, c_done, c_mreq, c_mwe;
    logic [2:0]           c_req = '0, c_gnt, c_we = '0, c_rvalid;
    logic [2:0][AW-1:0]   c_addr = '0;
    logic [2:0][7:0]      c_wdata = '0;
    logic [2:0][0:0]      c_be = '0;
    logic [7:0]           c_rdata, c_mwdata;
    logic [7:0]           c_mrdata = 8'h00;
    logic [AW-1:0]        c_maddr;
    logic [0:0]           c_mbe;

    mem_sram_sched #(.NumPorts(3), .NumWords(NW), .DataWidth(8), .InitEnable(1'b0)) dut3 (
        .clk_i(clk), .rst_ni(c_rst_n), .init_start_i(c_start), .init_done_o(c_done),
        .req_i(c_req), .gnt_o(c_gnt), .we_i(c_we), .addr_i(c_addr), .wdata_i(c_wdata), .be_i(c_be),
        .rvalid_o(c_rvalid), .rdata_o(c_rdata), .mem_req_o(c_mreq), .mem_we_o(c_mwe),
        .mem_addr_o(c_maddr), .mem_wdata_o(c_mwdata), .mem_be_o(c_mbe), .mem_rdata_i(c_mrdata)
    );

    // SRAM environment: latency-1 read register, updated only by reads.
    logic [DW-1:0] sram [NW];
    logic [DW-1:0] rdq;
    assign mem_rdata = rdq;
    always @(posedge clk) begin
        if (!rst_ni) begin
            for (int i = 0; i < NW; i++) sram[i] <= $urandom;
        end else if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                rdq <= sram[mem_addr];
            end
        end
    end

    int nchk = 0, nerr = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Behavioural model: phase 0=boot 1=init 2=run.
    int            ph, icnt, rr;
    logic [NP-1:0] m_rsp, last_gnt;
    logic          m_rsp_rd;
    logic [DW-1:0] m_rsp_data;
    logic [DW-1:0] gold [NW];

    task automatic model_reset();
        ph = 0; icnt = 0; rr = 0; m_rsp = '0; m_rsp_rd = 1'b0; last_gnt = '0;
    endtask

    task automatic step();
        logic [NP-1:0] eg;
        int w;
        @(negedge clk);
        eg = '0; w = -1;
        if (ph == 2)
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (rr + k) % NP;
                if (w < 0 && req[p]) w = p;
            end
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("init_done", 64'(init_done), 64'(ph == 2));
        chk("rvalid", 64'(rvalid), 64'(m_rsp));
        if (m_rsp != '0 && m_rsp_rd) chk("rdata", 64'(rdata), 64'(m_rsp_data));
        if (ph == 1) begin
            chk("init_req", 64'(mem_req), 64'd1);
            chk("init_we", 64'(mem_we), 64'd1);
            chk("init_addr", 64'(mem_addr), 64'(icnt));
            chk("init_wdata", 64'(mem_wdata), 64'd0);
            chk("init_be", 64'(mem_be), 64'hf);
        end else if (w >= 0) begin
            chk("mem_req", 64'(mem_req), 64'd1);
            chk("mem_we", 64'(mem_we), 64'(we[w]));
            chk("mem_addr", 64'(mem_addr), 64'(addr[w]));
            if (we[w]) begin
                chk("mem_wdata", 64'(mem_wdata), 64'(wdata[w]));
                chk("mem_be", 64'(mem_be), 64'(be[w]));
            end
        end else begin
            chk("mem_idle", 64'(mem_req), 64'd0);
        end
        @(posedge clk);
        last_gnt = eg; m_rsp = eg; m_rsp_rd = 1'b0;
        if (w >= 0) begin
            if (we[w]) begin
                for (int b = 0; b < BW; b++)
                    if (be[w][b]) gold[addr[w]][8*b +: 8] = wdata[w][8*b +: 8];
            end else begin
                m_rsp_rd = 1'b1;
                m_rsp_data = gold[addr[w]];
            end
            rr = (w + 1) % NP;
        end
        case (ph)
            0: ph = 1;
            1: begin
                gold[icnt] = '0;
                icnt++;
                if (icnt == NW) begin ph = 2; icnt = 0; end
            end
            default: if (init_start) ph = 1;
        endcase
        #1;
    endtask

    initial begin
        req = '0; we = '0; addr = '0; wdata = '0; be = '0; init_start = 1'b0;
        for (int i = 0; i < NW; i++) gold[i] = '0;
        model_reset();
        #2;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_done", 64'(init_done), 64'd0);
        #16 rst_ni = 1'b1;

        // Boot plus seven init writes, then reset in the middle of the pass.
        for (int i = 0; i < 8; i++) step();
        @(negedge clk);
        chk("init_addr7", 64'(mem_addr), 64'd7);
        #1 rst_ni = 1'b0;
        #1;
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_mem_we", 64'(mem_we), 64'd0);
        chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
        chk("midrst_mem_be", 64'(mem_be), 64'd0);
        chk("midrst_gnt", 64'(gnt), 64'd0);
        chk("midrst_done", 64'(init_done), 64'd0);
        model_reset();
        @(posedge clk); #3 rst_ni = 1'b1;
        for (int i = 0; i < 1 + NW; i++) step();
        chk("done_after_init", 64'(init_done), 64'd1);

        // Write then read back through the other port.
        req = 2'b01; we[0] = 1'b1; addr[0] = 4'd3; wdata[0] = 32'hA5A5A5A5; be[0] = 4'hf;
        step(); req = '0;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 4'd3;
        step(); req = '0;
        step();
        chk("rd_a5_rdata", 64'(rdata), 64'hA5A5A5A5);

        // Continuous contention alternates grants.
        req = 2'b11; we = 2'b00;
        for (int i = 0; i < 6; i++) begin
            addr[0] = 4'($urandom_range(0, 15)); addr[1] = 4'($urandom_range(0, 15));
            step();
            chk("alternate", 64'(last_gnt), (i % 2) ? 64'd2 : 64'd1);
        end
        req = '0;

        // Re-init with an in-flight read and a request held across INIT.
        req = 2'b01; we[0] = 1'b1; addr[0] = 4'd5; wdata[0] = 32'h12345678; be[0] = 4'hf;
        step(); req = '0;
        step();
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 4'd5; init_start = 1'b1;
        step(); req = '0; init_start = 1'b0;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'd5;
        step();
        chk("reinit_rdata", 64'(rdata), 64'h12345678);
        for (int i = 1; i < NW; i++) step();
        step();
        chk("held_req_gnt", 64'(last_gnt), 64'd1);
        req = '0;
        step();
        chk("reinit_zero", 64'(rdata), 64'd0);

        // Randomized traffic with occasional re-init pulses.
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < NP; p++)
                if (!req[p] && $urandom_range(0, 2) != 0) begin
                    req[p] = 1'b1;
                    we[p] = 1'($urandom_range(0, 1));
                    addr[p] = 4'($urandom_range(0, 15));
                    wdata[p] = $urandom;
                    be[p] = 4'($urandom_range(0, 15));
                end
            init_start = ($urandom_range(0, 59) == 0);
            step();
            init_start = 1'b0;
            for (int p = 0; p < NP; p++) if (last_gnt[p]) req[p] = 1'b0;
        end

        // Three ports: drive rr_ptr to 2, then req=011 must wrap to port 0.
        @(posedge clk); #1 c_rst_n = 1'b1;
        @(negedge clk);
        chk("p3_boot_done", 64'(c_done), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("p3_run_done", 64'(c_done), 64'd1);
        @(posedge clk); #1 c_req = 3'b010;
        @(negedge clk);
        chk("p3_gnt1", 64'(c_gnt), 64'b010);
        @(posedge clk); #1 c_req = 3'b011;
        @(negedge clk);
        chk("p3_wrap_gnt", 64'(c_gnt), 64'b001);
        chk("p3_rvalid", 64'(c_rvalid), 64'b010);
        @(posedge clk); #1;
        @(negedge clk);
        chk("p3_ptr1_gnt", 64'(c_gnt), 64'b010);
        chk("p3_rvalid0", 64'(c_rvalid), 64'b001);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
